matmul_sequencer: RTL

Parametrised control sequencer for the matrix-multiplication datapath, the next generation of the fixed prepare/process/complete state controller. It walks every output element (row, col) of a ROWS×COLS result, clears the accumulator, and gates INNER multiply-accumulate steps on operand availability. It then issues a write with a ready handshake and reports completion. It also adds restart-from-done, stall handling, and an element index bus for address generation.

---
 rtl/matmul_pkg.sv | 21 ++
 rtl/matmul_index_counter.sv | 51 +++++
 rtl/matmul_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg
// Shared definitions for the matrix-multiply control sequencer.
//   state_e   : FSM state encoding, also driven out as the 3-bit status code
//   idx_width : width of an index bus for a dimension of size n (at least 1 bit)

package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_CLEAR = 3'b001,
    ST_MAC   = 3'b010,
    ST_WRITE = 3'b011,
    ST_DONE  = 3'b111
  } state_e;

  // A dimension of size 1 still needs a 1-bit index bus (always 0).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_index_counter.sv
// matmul_index_counter
// Wrap-around index counter running 0 .. N-1.
//   clock, reset_n : clock and asynchronous active-low reset
//   inc            : advance by one (wraps to 0 after N-1)
//   clr            : force the count to 0 (takes priority over inc)
//   count          : current index
//   last           : count is at N-1
//   wrap           : this cycle's inc takes the count from N-1 back to 0

module matmul_index_counter
  import matmul_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_width(N)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         last,
  output logic         wrap
);

  localparam logic [W-1:0] MAX = W'(N - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign last  = (count_q == MAX);
  assign wrap  = inc && last && !clr;
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = last ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer
// Control sequencer for a matrix-multiply datapath. Walks every (row, col)
// element of a ROWS x COLS result: clears the accumulator, runs INNER MAC
// steps gated by operand availability, then holds a write request until the
// sink accepts it. Reports completion and can be restarted from DONE.
//   clock, reset_n    : clock and asynchronous active-low reset
//   start             : begin a run (honoured only in IDLE or DONE)
//   operand_valid     : operand pair for the current k is present
//   write_ready       : result sink accepts the accumulator this cycle
//   status            : state code (IDLE 000, CLEAR 001, MAC 010, WRITE 011, DONE 111)
//   clear_acc         : zero the accumulator (one cycle per element)
//   mac_en            : accumulate the current operand pair
//   write_en          : result write request, held until accepted
//   row_idx/col_idx/k_idx : current element and inner index for address generation
//   busy              : high in CLEAR, MAC and WRITE
//   done              : high in DONE

module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int INNER = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        operand_valid,
  input  logic                        write_ready,
  output logic [2:0]                  status,
  output logic                        clear_acc,
  output logic                        mac_en,
  output logic                        write_en,
  output logic [idx_width(ROWS)-1:0]  row_idx,
  output logic [idx_width(COLS)-1:0]  col_idx,
  output logic [idx_width(INNER)-1:0] k_idx,
  output logic                        busy,
  output logic                        done
);

  localparam int RW = idx_width(ROWS);
  localparam int CW = idx_width(COLS);
  localparam int KW = idx_width(INNER);

  state_e state_q, state_d;
  logic   clear_acc_q, clear_acc_d;
  logic   write_en_q, write_en_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  logic start_accept;
  logic write_accept;
  logic final_element;
  logic k_inc, k_clr, k_last, k_wrap;
  logic col_inc, col_last, col_wrap;
  logic row_last, row_wrap;

  assign start_accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign write_accept  = (state_q == ST_WRITE) && write_ready;
  assign final_element = row_last && col_last;

  assign k_inc = (state_q == ST_MAC) && operand_valid;
  assign k_clr = (state_q == ST_CLEAR) || start_accept;

  // The column counter is frozen on the final element so that row/col keep
  // their final values in DONE; a column wrap is what advances the row.
  assign col_inc = write_accept && !final_element;

  matmul_index_counter #(.N(INNER), .W(KW)) u_k_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (k_inc),
    .clr     (k_clr),
    .count   (k_idx),
    .last    (k_last),
    .wrap    (k_wrap)
  );

  matmul_index_counter #(.N(COLS), .W(CW)) u_col_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (col_inc),
    .clr     (start_accept),
    .count   (col_idx),
    .last    (col_last),
    .wrap    (col_wrap)
  );

  matmul_index_counter #(.N(ROWS), .W(RW)) u_row_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (col_wrap),
    .clr     (start_accept),
    .count   (row_idx),
    .last    (row_last),
    .wrap    (row_wrap)
  );

  // Next-state logic; registered outputs are decoded from the next state so
  // they line up with state_q after the edge. row_wrap can only fire if the
  // walk ran past the final element, which also ends the run.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_MAC;
      ST_MAC:   if (k_wrap) state_d = ST_WRITE;
      ST_WRITE: begin
        if (write_accept) begin
          state_d = (final_element || row_wrap) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_DONE:  if (start) state_d = ST_CLEAR;
      default:  state_d = ST_IDLE;
    endcase

    clear_acc_d = (state_d == ST_CLEAR);
    write_en_d  = (state_d == ST_WRITE);
    busy_d      = (state_d == ST_CLEAR) || (state_d == ST_MAC) || (state_d == ST_WRITE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      clear_acc_q <= 1'b0;
      write_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_acc_q <= clear_acc_d;
      write_en_q  <= write_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign status    = state_q;
  assign clear_acc = clear_acc_q;
  assign write_en  = write_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  // Only output with a combinational path from an input.
  assign mac_en    = (state_q == ST_MAC) && operand_valid;

endmodule
